// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, quarter indices and translator address constants shared by the
// I2C address forwarder and its quarter-period divider.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_STOP  = 3'd5
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] PHYS_ADDR = 7'h48;
  localparam logic [6:0] VIRT_ADDR = 7'h49;

  // Open-drain: a 0 data bit is driven by pulling SDA low.
  function automatic logic sda_drive(input logic bit_v);
    return ~bit_v;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: SCL quarter-period divider. Counts 0..CLK_DIV-1 while enabled, strobes tick at
// the wrap, and freezes while hold is asserted (slave clock stretching).
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Wrap strobe; suppressed while frozen so a stretched quarter never ends early.
  always_comb begin
    tick = en & ~clr & ~hold & (r_cnt == LAST);
  end

  // Quarter counter, parked at zero whenever the sequencer is not timing a quarter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else if (hold) begin
      r_cnt <= r_cnt;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_addr_forwarder.sv
// i2c_addr_forwarder: re-issues a translated address + R/W as single master on the physical
// bus (START, address byte, ACK, hold until STOP). Define I2C_FWD_STRETCH_EN for clock stretching.
module i2c_addr_forwarder
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              rw_in,
  input  logic              stop_req,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_pd,
  output logic              sda_pd,
  output logic              busy,
  output logic              done,
  output logic              ack_ok,
  output logic [2:0]        state_o
);

  localparam int SH_W = ADDR_W + 1;
  localparam int BC_W = $clog2(SH_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(ADDR_W);

`ifdef I2C_FWD_STRETCH_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  i2c_state_e      r_state;
  logic [1:0]      r_q;
  logic [BC_W-1:0] r_bitcnt;
  logic [SH_W-1:0] r_shift;
  logic            r_sampled;

  logic w_tick;
  logic w_cnt_en;
  logic w_stretch;
  logic w_start_acc;

  // Quarter timing runs only in the states that shape SCL edges.
  always_comb begin
    w_cnt_en = 1'b0;
    case (r_state)
      ST_START, ST_BIT, ST_ACK, ST_STOP: w_cnt_en = 1'b1;
      default:                           w_cnt_en = 1'b0;
    endcase
  end

  // A slave holding SCL low during the released high quarter stretches that quarter.
  assign w_stretch   = STRETCH_EN & ~scl_i & (r_q == Q2) &
                       (r_state inside {ST_BIT, ST_ACK, ST_STOP});
  assign w_start_acc = (r_state == ST_IDLE) & start_req;
  assign state_o     = r_state;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_cnt_en),
    .clr     (w_start_acc),
    .hold    (w_stretch),
    .tick    (w_tick)
  );

  // Transaction sequencer: state and every pad/status output update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_q       <= Q0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_sampled <= 1'b0;
      scl_pd    <= 1'b0;
      sda_pd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_ok    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_req) begin
            r_shift  <= {addr_in, rw_in};
            r_bitcnt <= '0;
            r_q      <= Q0;
            ack_ok   <= 1'b0;
            busy     <= 1'b1;
            sda_pd   <= 1'b1;
            scl_pd   <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_q == Q1) begin
              r_q     <= Q0;
              scl_pd  <= 1'b1;
              sda_pd  <= sda_drive(r_shift[SH_W-1]);
              r_state <= ST_BIT;
            end else begin
              r_q <= r_q + 2'd1;
            end
          end
        end
        ST_BIT: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              Q1: scl_pd <= 1'b0;
              Q3: begin
                scl_pd   <= 1'b1;
                r_shift  <= {r_shift[SH_W-2:0], 1'b0};
                r_bitcnt <= r_bitcnt + BC_W'(1);
                if (r_bitcnt == LAST_BIT) begin
                  sda_pd  <= 1'b0;
                  r_state <= ST_ACK;
                end else begin
                  sda_pd <= sda_drive(r_shift[SH_W-2]);
                end
              end
              default: ;
            endcase
          end
        end
        ST_ACK: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              Q1: scl_pd <= 1'b0;
              Q2: r_sampled <= sda_i;
              Q3: begin
                done   <= 1'b1;
                ack_ok <= ~r_sampled;
                scl_pd <= 1'b1;
                // A NACK closes the bus on its own; an ACK parks it for the caller.
                if (r_sampled) begin
                  sda_pd  <= 1'b1;
                  r_state <= ST_STOP;
                end else begin
                  sda_pd  <= 1'b0;
                  r_state <= ST_HOLD;
                end
              end
              default: ;
            endcase
          end
        end
        ST_HOLD: begin
          if (stop_req) begin
            r_q     <= Q0;
            scl_pd  <= 1'b1;
            sda_pd  <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              Q0: scl_pd <= 1'b0;
              Q1: sda_pd <= 1'b0;
              Q3: begin
                busy    <= 1'b0;
                scl_pd  <= 1'b0;
                sda_pd  <= 1'b0;
                r_state <= ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_q     <= Q0;
          busy    <= 1'b0;
          scl_pd  <= 1'b0;
          sda_pd  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_addr_forwarder.sv
// tb_i2c_addr_forwarder: directed and random stimulus, outputs compared every cycle against a
// timeline model that derives pad levels from elapsed quarters since the accepted request.
`timescale 1ns/1ps
module tb_i2c_addr_forwarder;
  import i2c_pkg::*;

  localparam int D = 4;
`ifdef I2C_FWD_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       start_req = 1'b0, stop_req = 1'b0, rw_in = 1'b0;
  logic       scl_i = 1'b1, sda_i = 1'b1;
  logic [6:0] addr_in = 7'h00;
  logic       scl_pd, sda_pd, busy, done, ack_ok;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  i2c_addr_forwarder #(.CLK_DIV(D), .ADDR_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .start_req(start_req), .addr_in(addr_in), .rw_in(rw_in),
    .stop_req(stop_req), .scl_i(scl_i), .sda_i(sda_i), .scl_pd(scl_pd), .sda_pd(sda_pd),
    .busy(busy), .done(done), .ack_ok(ack_ok), .state_o(state_o)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase 0 idle, 1 transfer, 2 hold, 3 stop; m_e = unstalled cycles into the phase.
  int         m_ph = 0, m_e = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_done = 1'b0, m_ack_ok = 1'b0, m_samp = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    int q;
    bit stall;
    if (!reset_n) begin
      m_ph = 0; m_e = 0; m_byte = 8'h00; m_done = 1'b0; m_ack_ok = 1'b0; m_samp = 1'b0;
    end else begin
      m_done = 1'b0;
      q = m_e / D;
      case (m_ph)
        0: if (start_req) begin
          m_byte = {addr_in, rw_in}; m_e = 0; m_ack_ok = 1'b0; m_ph = 1;
        end
        1: begin
          stall = STR && q >= 2 && ((q - 2) % 4) == 2 && !scl_i;
          if (q == 36 && (m_e % D) == D - 1 && !stall) m_samp = sda_i;
          if (!stall) m_e = m_e + 1;
          if (m_e == 38 * D) begin
            m_done = 1'b1; m_ack_ok = !m_samp; m_ph = m_samp ? 3 : 2; m_e = 0;
          end
        end
        2: if (stop_req) begin m_ph = 3; m_e = 0; end
        3: begin
          stall = STR && q == 2 && !scl_i;
          if (!stall) m_e = m_e + 1;
          if (m_e == 4 * D) m_ph = 0;
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    int q;
    logic es, ed;
    int est;
    q = m_e / D;
    es = 1'b0; ed = 1'b0; est = 0;
    case (m_ph)
      1: begin
        if (q < 2) begin es = 1'b0; ed = 1'b1; est = 1; end
        else if (q < 34) begin
          es = ((q - 2) % 4) < 2; ed = ~m_byte[7 - (q - 2) / 4]; est = 2;
        end else begin es = (q - 34) < 2; ed = 1'b0; est = 3; end
      end
      2: begin es = 1'b1; ed = 1'b0; est = 4; end
      3: begin es = (q == 0); ed = (q < 2); est = 5; end
      default: ;
    endcase
    if (cyc > 0) begin
      n_tests++;
      if (scl_pd !== es || sda_pd !== ed || busy !== (m_ph != 0) || done !== m_done ||
          ack_ok !== m_ack_ok || int'(state_o) != est) begin
        n_fail++;
        $display("FAIL cycle_compare @%0d: got scl=%b sda=%b busy=%b done=%b ack=%b st=%0d, expected scl=%b sda=%b busy=%b done=%b ack=%b st=%0d",
                 cyc, scl_pd, sda_pd, busy, done, ack_ok, state_o, es, ed, (m_ph != 0), m_done, m_ack_ok, est);
      end
    end
  end

  // Bus monitor: data bit on each SCL release (first 8), and SDA rising while SCL is high.
  logic [7:0] cap = 8'h00;
  int         cap_n = 0;
  logic       stop_seen = 1'b0, prev_scl = 1'b0, prev_sda = 1'b0;
  always @(negedge clk) begin
    if (prev_scl && !scl_pd && cap_n < 8) begin
      cap = {cap[6:0], ~sda_pd}; cap_n = cap_n + 1;
    end
    if (prev_sda && !sda_pd && !scl_pd) stop_seen = 1'b1;
    prev_scl = scl_pd; prev_sda = sda_pd;
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  int t0, td, ti, ts;
  logic ack_seen;

  task automatic start_xfer(input logic [6:0] a, input logic rw, input logic sda_v, input logic with_stop);
    @(negedge clk); #1;
    addr_in = a; rw_in = rw; sda_i = sda_v; cap = 8'h00; cap_n = 0; stop_seen = 1'b0;
    start_req = 1'b1; stop_req = with_stop;
    @(negedge clk); #1;
    start_req = 1'b0; stop_req = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(input int bound);
    td = -1;
    for (int i = 0; i < bound; i++) begin
      if (done) begin td = cyc; ack_seen = ack_ok; break; end
      @(negedge clk); #1;
    end
    if (td < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    ti = -1;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin ti = cyc; break; end
      @(negedge clk); #1;
    end
    if (ti < 0) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (cap_n >= n) break;
    end
    if (cap_n < n) check("bit_wait_timeout", cap_n, n);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      stop_req = (state_o == 3'd4);
      @(negedge clk); #1;
    end
    stop_req = 1'b0;
    check("go_idle", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_scl", int'(scl_pd), 0);
    check("reset_sda", int'(sda_pd), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(state_o), 0);
    reset_n = 1'b1;

    // ACKed 0x48 write: byte 1001_0000, done at cycle 1+8+144, bus parked in HOLD.
    start_xfer(PHYS_ADDR, 1'b0, 1'b0, 1'b0);
    wait_done(400);
    check("ack_latency", 1 + td - t0, 153);
    check("ack_bits", int'(cap), 32'h90);
    check("ack_ok_set", int'(ack_seen), 1);
    check("hold_state", int'(state_o), 4);
    check("hold_scl", int'(scl_pd), 1);

    repeat (5) @(negedge clk);
    #1;
    stop_seen = 1'b0; stop_req = 1'b1;
    @(negedge clk); #1;
    stop_req = 1'b0; ts = cyc;
    wait_idle(100);
    check("hold_stop_len", ti - ts, 4 * D);
    check("hold_stop_cond", int'(stop_seen), 1);

    // NACK: automatic STOP four quarters after done.
    start_xfer(PHYS_ADDR, 1'b0, 1'b1, 1'b0);
    wait_done(400);
    check("nack_latency", 1 + td - t0, 153);
    check("nack_ack_ok", int'(ack_seen), 0);
    check("nack_state", int'(state_o), 5);
    wait_idle(100);
    check("nack_stop_len", ti - td, 4 * D);
    check("nack_stop_cond", int'(stop_seen), 1);

    // start_req during BIT must not disturb the byte in flight.
    start_xfer(7'h55, 1'b1, 1'b0, 1'b0);
    repeat (3 * D) @(negedge clk);
    #1;
    check("bit_state", int'(state_o), 2);
    addr_in = 7'h00; rw_in = 1'b0; start_req = 1'b1;
    @(negedge clk); #1;
    start_req = 1'b0;
    wait_done(400);
    check("ignore_latency", 1 + td - t0, 153);
    check("ignore_bits", int'(cap), 32'hAB);
    go_idle();

    // Async reset in the middle of bit 3 releases both lines at once.
    start_xfer(7'h00, 1'b0, 1'b0, 1'b0);
    wait_cap(3);
    repeat (2 * D) @(negedge clk);
    #2;
    check("pre_reset_scl", int'(scl_pd), 1);
    check("pre_reset_sda", int'(sda_pd), 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_scl", int'(scl_pd), 0);
    check("mid_reset_sda", int'(sda_pd), 0);
    check("mid_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    start_xfer(7'h21, 1'b1, 1'b0, 1'b0);
    wait_done(400);
    check("post_reset_bits", int'(cap), 32'h43);
    check("post_reset_latency", 1 + td - t0, 153);
    go_idle();

    // SCL held low by the slave for 20 cycles in bit 5 high quarter.
    start_xfer(7'h3C, 1'b0, 1'b0, 1'b0);
    wait_cap(6);
    scl_i = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    scl_i = 1'b1;
    wait_done(400);
    check("stretch_latency", td - t0, 152 + (STR ? 20 : 0));
    go_idle();

    // start_req and stop_req together in IDLE: start wins.
    start_xfer(VIRT_ADDR, 1'b0, 1'b0, 1'b1);
    wait_done(400);
    check("startstop_latency", 1 + td - t0, 153);
    check("startstop_bits", int'(cap), 32'h92);
    check("startstop_state", int'(state_o), 4);
    go_idle();

    // Random traffic; the per-cycle compare covers it.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      start_req = ($urandom_range(0, 9) == 0);
      stop_req  = ($urandom_range(0, 5) == 0);
      addr_in   = 7'($urandom);
      rw_in     = 1'($urandom);
      sda_i     = 1'($urandom);
      scl_i     = ($urandom_range(0, 5) != 0);
    end
    start_req = 1'b0; stop_req = 1'b0; scl_i = 1'b1;
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_addr_forwarder.md
Name: i2c_addr_forwarder

Overview:
- Downstream stage of the I2C address translator: takes the translated 7-bit address and R/W bit and re-issues them on the physical-side I2C bus as a single master.
- Sequence per request: START, 8 address/RW bits MSB first, ACK sampling, then bus hold until a STOP is requested.
- Drives SCL/SDA as open-drain pull-down enables. The top level owns the tri-state pads.

Parameters:
- CLK_DIV, 125, system clocks per SCL quarter-period (must be ≥2); full SCL period = 4*CLK_DIV.
- ADDR_W, 7, address width; shift length = ADDR_W+1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- start_req  input  1  one-cycle request to forward; sampled only in IDLE
- addr_in  input  ADDR_W  translated address, captured on accepted start_req
- rw_in  input  1  R/W bit, captured with addr_in
- stop_req  input  1  one-cycle request to end transaction; honoured only in HOLD
- scl_i  input  1  synchronised SCL pad level
- sda_i  input  1  synchronised SDA pad level
- scl_pd  output  1  1 = pull SCL low
- sda_pd  output  1  1 = pull SDA low
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when ACK slot is sampled
- ack_ok  output  1  valid with done: 1 = slave ACKed (sda_i=0)
- state_o  output  3  current FSM state for debug

Behaviour:
- Reset (async, reset_n=0): state IDLE; scl_pd=0, sda_pd=0, busy=0, done=0, ack_ok=0; quarter counter, bit counter and shift register cleared. Lines release immediately, even mid-byte.
- Quarter tick: counter runs 0..CLK_DIV-1 while busy and emits a tick at wrap. It is held at 0 in IDLE and HOLD.
- FSM states: IDLE=0, START=1, BIT=2, ACK=3, HOLD=4, STOP=5.
- IDLE: on start_req, load shift = {addr_in, rw_in}, bitcnt=0, go to START next cycle. A start_req in any other state is ignored with no queueing.
- START: sda_pd=1 with SCL released. After 2 ticks, scl_pd=1 and go to BIT.
- BIT, per bit, 4 quarters:
  - q0: SCL low, SDA set to shift MSB (sda_pd = ~bit).
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL released.
  - End of q3: SCL pulled low, shift left, bitcnt+1.
  - After bit ADDR_W (8th bit), go to ACK.
- ACK: sda_pd=0, same 4-quarter SCL pattern. sda_i sampled at end of q2.
  - At the end of q3: done=1 for one cycle, ack_ok = ~sampled.
  - ACK → HOLD. NACK → STOP automatically.
- HOLD: scl_pd=1, sda_pd=0. Waits indefinitely; stop_req → STOP.
- STOP sequence:
  - q0: sda_pd=1, SCL low.
  - q1: SCL released.
  - q2: sda_pd=0 (STOP condition).
  - q3: return to IDLE.
- ack_ok holds its value until the next accepted start_req, then clears.
- start_req and stop_req in the same IDLE cycle: start wins, stop ignored.
- Latency start_req→first SCL fall = 1 + 2*CLK_DIV cycles. start_req→done = 1 + 2*CLK_DIV + 9*4*CLK_DIV cycles with no stretching.

Optional Feature:
- Macro: I2C_FWD_STRETCH_EN.
- Defined: in BIT/ACK/STOP quarter q2, the quarter counter does not advance while scl_i=0 after SCL is released (slave clock stretching). Wait is unbounded.
- Undefined: scl_i is ignored; timing is purely counter-driven.

Decomposition:
- Shared package i2c_pkg: state encoding localparams (IDLE..STOP); the 7-bit address constants already used by the translator (0x48 physical, 0x49 virtual).
- Sub-module i2c_qtick: quarter-period divider with enable/clear and a stretch-hold input. Instantiated once.

Test Plan:
- CLK_DIV=4, addr_in=0x48, rw_in=0, slave ACKs → SDA bits on SCL rises 1,0,0,1,0,0,0,0; done pulse with ack_ok=1 at cycle 1+8+144=153; state HOLD, scl_pd=1.
- Same with sda_i held 1 in ACK → done with ack_ok=0; automatic STOP (SDA rises while SCL high); IDLE, busy=0 after 4 more ticks.
- In HOLD, pulse stop_req → STOP waveform, then IDLE. A start_req pulsed during BIT is ignored: no second transfer, shift unchanged.
- Assert reset_n=0 at bit 3 → scl_pd=sda_pd=0 in the same cycle, busy=0; release, then new start_req with addr 0x21 rw 1 → bits 0100_0011.
- With I2C_FWD_STRETCH_EN, hold scl_i low 20 cycles in bit 5 q2 → done is delayed by exactly 20 cycles. Without the macro, delay is 0.
- start_req and stop_req together in IDLE → transfer starts normally; stop has no effect.
